// File: rtl/reg_file_rn_if.sv
// Operand-read, rename, commit and flush bundle between the issuer/ROB side
// (master) and the renaming register file (slave).
interface reg_file_rn_if #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 4,
  parameter int NUM_RD   = 2
);
  localparam int IDX_W = $clog2(REG_NUM);
  localparam int CNT_W = IDX_W + 1;

  logic [NUM_RD*IDX_W-1:0]    rd_idx;
  logic [NUM_RD*XLEN-1:0]     rd_val;
  logic [NUM_RD*ROB_ID_W-1:0] rd_tag;

  logic                       ren_valid;
  logic [IDX_W-1:0]           ren_rd;
  logic [ROB_ID_W-1:0]        ren_tag;

  logic                       cmt_valid;
  logic [IDX_W-1:0]           cmt_rd;
  logic [ROB_ID_W-1:0]        cmt_tag;
  logic [XLEN-1:0]            cmt_val;

  logic                       flush;
  logic [CNT_W-1:0]           pending_cnt;

  modport master (
    output rd_idx, ren_valid, ren_rd, ren_tag,
    output cmt_valid, cmt_rd, cmt_tag, cmt_val, flush,
    input  rd_val, rd_tag, pending_cnt
  );

  modport slave (
    input  rd_idx, ren_valid, ren_rd, ren_tag,
    input  cmt_valid, cmt_rd, cmt_tag, cmt_val, flush,
    output rd_val, rd_tag, pending_cnt
  );
endinterface

// File: rtl/reg_file_rn.sv
// Architectural register file with per-register producer ROB tag (rename status).
// Optional macro REG_FILE_BYPASS_EN forwards a matching commit to reads in the same cycle.
module reg_file_rn #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 4,
  parameter int NUM_RD   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  reg_file_rn_if.slave bus
);
  localparam int IDX_W = $clog2(REG_NUM);
  localparam int CNT_W = IDX_W + 1;

  logic [XLEN-1:0]     values [REG_NUM];
  logic [ROB_ID_W-1:0] status [REG_NUM];
  logic [CNT_W-1:0]    pending_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                cmt_hit;
  logic                cmt_clears;
  logic                ren_hit;
  logic                same_reg;

  always_comb begin
    cmt_hit    = bus.cmt_valid && (bus.cmt_rd != '0);
    // Only the youngest producer may clear status; an older commit leaves the rename in place.
    cmt_clears = cmt_hit && (status[bus.cmt_rd] != '0) && (status[bus.cmt_rd] == bus.cmt_tag);
    ren_hit    = bus.ren_valid && (bus.ren_rd != '0) && !bus.flush;
    same_reg   = ren_hit && cmt_hit && (bus.ren_rd == bus.cmt_rd);
    cnt_next   = pending_cnt;
    if (bus.flush) begin
      cnt_next = '0;
    end else begin
      if (ren_hit && (status[bus.ren_rd] == '0)) cnt_next = cnt_next + CNT_W'(1);
      if (cmt_clears && !same_reg)               cnt_next = cnt_next - CNT_W'(1);
    end
  end

  // NOTE: the value array is reset too, because reads must return zero after reset;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        values[i] <= '0;
        status[i] <= '0;
      end
      pending_cnt <= '0;
    end else if (rdy) begin
      if (cmt_hit) values[bus.cmt_rd] <= bus.cmt_val;
      if (bus.flush) begin
        for (int i = 0; i < REG_NUM; i++) status[i] <= '0;
      end else begin
        // NOTE: non-blocking, last assignment wins, so a same-register rename overrides the clear.
        if (cmt_clears) status[bus.cmt_rd] <= '0;
        if (ren_hit)    status[bus.ren_rd] <= bus.ren_tag;
      end
      pending_cnt <= cnt_next;
    end
  end

  assign bus.pending_cnt = pending_cnt;

  logic [NUM_RD*XLEN-1:0]     rd_val_w;
  logic [NUM_RD*ROB_ID_W-1:0] rd_tag_w;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_W-1:0]    idx;
    logic [ROB_ID_W-1:0] tag;
    logic [XLEN-1:0]     val;

    always_comb begin
      idx = bus.rd_idx[p*IDX_W +: IDX_W];
      tag = status[idx];
      val = ((tag != '0) || (idx == '0)) ? '0 : values[idx];
`ifdef REG_FILE_BYPASS_EN
      if (bus.cmt_valid && (idx != '0) && (idx == bus.cmt_rd) && (bus.cmt_tag == tag)) begin
        tag = '0;
        val = bus.cmt_val;
      end
`endif
    end

    assign rd_val_w[p*XLEN +: XLEN]         = val;
    assign rd_tag_w[p*ROB_ID_W +: ROB_ID_W] = tag;
  end

  assign bus.rd_val = rd_val_w;
  assign bus.rd_tag = rd_tag_w;

  // Running count must always match the number of registers with a pending producer.
  logic [REG_NUM-1:0] busy;
  always_comb begin
    busy = '0;
    for (int i = 0; i < REG_NUM; i++) busy[i] = (status[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (pending_cnt == CNT_W'($countones(busy)));
  end
endmodule
